// File: rtl/add4_operand_seq.sv
// Operand sequencer feeding an external ripple-carry adder: captures A, then B+cin,
// latches sum/cout. Optional running-sum mode selected by macro ACCUMULATE_EN.
module add4_operand_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             result_valid,
  output logic             ovf,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_ADD  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t           st, st_nx;
  logic             step_q, rise;
  logic [WIDTH-1:0] a_nx, b_nx, res_nx;
  logic             cin_nx, carry_nx, vld_nx;

  assign rise    = step & ~step_q;
  assign state_o = st;

  // step_q follows the button even during reset, so a button held across
  // reset release is not seen as a fresh press.
  always_ff @(posedge clk) begin
    step_q <= step;
    if (reset) begin
      st           <= S_A;
      add_a        <= '0;
      add_b        <= '0;
      add_cin      <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      st           <= st_nx;
      add_a        <= a_nx;
      add_b        <= b_nx;
      add_cin      <= cin_nx;
      result       <= res_nx;
      carry        <= carry_nx;
      result_valid <= vld_nx;
    end
  end

`ifdef ACCUMULATE_EN
  logic ovf_q;

  // Sticky: only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                     ovf_q <= 1'b0;
    else if (st == S_ADD && add_cout) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    st_nx    = st;
    a_nx     = add_a;
    b_nx     = add_b;
    cin_nx   = add_cin;
    res_nx   = result;
    carry_nx = carry;
    vld_nx   = result_valid;
    unique case (st)
      S_A: if (rise) begin
        a_nx   = data_in;
        vld_nx = 1'b0;
        st_nx  = S_B;
      end
      S_B: if (rise) begin
        b_nx   = data_in;
        cin_nx = cin_in;
        st_nx  = S_ADD;
      end
      // Operands are already registered, so the adder has had a full cycle to settle.
      S_ADD: begin
        res_nx   = add_sum;
        carry_nx = add_cout;
        vld_nx   = 1'b1;
        st_nx    = S_SHOW;
      end
      S_SHOW: if (rise) begin
        vld_nx = 1'b0;
`ifdef ACCUMULATE_EN
        a_nx   = result;
        st_nx  = S_B;
`else
        st_nx  = S_A;
`endif
      end
      default: st_nx = S_A;
    endcase
  end

endmodule

// File: tb/tb_add4_operand_seq.sv
// Directed bench for add4_operand_seq; models the external 4-bit adder itself.
// Build with +define+ACCUMULATE_EN to exercise running-sum mode.
module tb_add4_operand_seq;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset, step, cin_in, add_cin, add_cout, carry, result_valid, ovf;
  logic [WIDTH-1:0] data_in, add_a, add_b, add_sum, result;
  logic [1:0]       state_o;
  logic [WIDTH:0]   sum5;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the FA chain downstream of the sequencer.
  assign sum5              = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign {add_cout, add_sum} = sum5;

  add4_operand_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .step(step), .data_in(data_in), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .add_cout(add_cout), .result(result), .carry(carry),
    .result_valid(result_valid), .ovf(ovf), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic hold_step);
    @(negedge clk);
    reset = 1'b1;
    step  = hold_step;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle press; returns at the negedge after the capturing posedge.
  task automatic press(input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    data_in = d;
    cin_in  = c;
    step    = 1'b1;
    @(negedge clk);
    step    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; step = 1'b0; data_in = '0; cin_in = 1'b0;

    // 1: reset state, button held through release
    do_reset(1'b1);
    chk("rst_a",     add_a, 0);
    chk("rst_b",     add_b, 0);
    chk("rst_res",   {carry, result}, 0);
    chk("rst_vld",   result_valid, 0);
    chk("rst_ovf",   ovf, 0);
    data_in = 4'h5;
    repeat (3) @(negedge clk);
    chk("held_state", state_o, 0);
    chk("held_a",     add_a, 0);
    step = 1'b0;

    // 2: 3 + 4 + 0 = 7, valid on the second edge counting the B capture edge
    do_reset(1'b0);
    press(4'h3, 1'b0);
    chk("t2_a",      add_a, 4'h3);
    chk("t2_st_b",   state_o, 1);
    press(4'h4, 1'b0);
    chk("t2_st_add", state_o, 2);
    chk("t2_vld_e1", result_valid, 0);
    @(negedge clk);
    chk("t2_vld_e2", result_valid, 1);
    chk("t2_res",    {carry, result}, 5'h07);
    chk("t2_st_sh",  state_o, 3);
    repeat (3) @(negedge clk);
    chk("t2_hold",   {result_valid, carry, result}, 6'h27);

    // 3: F + 1 + 1 = 0x11
    do_reset(1'b0);
    press(4'hF, 1'b0);
    press(4'h1, 1'b1);
    @(negedge clk);
    chk("t3_res",    {carry, result}, 5'h11);
    chk("t3_cin",    add_cin, 1);
    press(4'h0, 1'b0);
    chk("t3_vld_cl", result_valid, 0);
`ifdef ACCUMULATE_EN
    chk("t3_st",     state_o, 1);
`else
    chk("t3_st",     state_o, 0);
`endif

    // 4: 50-cycle hold captures A once; step held through S_ADD
    do_reset(1'b0);
    @(negedge clk);
    data_in = 4'h6; step = 1'b1;
    @(negedge clk);
    data_in = 4'hA;
    repeat (49) @(negedge clk);
    chk("t4_a",      add_a, 4'h6);
    chk("t4_st",     state_o, 1);
    chk("t4_b",      add_b, 0);
    step = 1'b0;
    @(negedge clk);
    data_in = 4'h2; step = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_st_sh",  state_o, 3);
    chk("t4_res",    {carry, result}, 5'h08);
    step = 1'b0;

    // 5: reset mid-operation discards A
    do_reset(1'b0);
    press(4'h9, 1'b0);
    chk("t5_pre_a",  add_a, 4'h9);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_a",      add_a, 0);
    chk("t5_st",     state_o, 0);
    chk("t5_vld",    result_valid, 0);

`ifdef ACCUMULATE_EN
    // 6: running sum 8+5=D, D+5=0x12 (ovf), 2+1=3 (ovf sticky)
    do_reset(1'b0);
    press(4'h8, 1'b0);
    press(4'h5, 1'b0);
    @(negedge clk);
    chk("t6_r1",     {carry, result}, 5'h0D);
    chk("t6_ovf1",   ovf, 0);
    press(4'h0, 1'b0);
    chk("t6_fb_a",   add_a, 4'hD);
    press(4'h5, 1'b0);
    @(negedge clk);
    chk("t6_r2",     {carry, result}, 5'h12);
    chk("t6_ovf2",   ovf, 1);
    press(4'h0, 1'b0);
    press(4'h1, 1'b0);
    @(negedge clk);
    chk("t6_r3",     {carry, result}, 5'h03);
    chk("t6_ovf3",   ovf, 1);
`else
    chk("ovf_tied",  ovf, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
